// File: rtl/alu32_issue.sv
// Issue/retire sequencer in front of the 32-bit ALU: one op in flight, valid/ready on both sides.
// Optional retire counter on op_count is built only when ALU_ISSUE_PERF_EN is defined.
module alu32_issue #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic [31:0] alu_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [15:0] op_count
);

  localparam logic [2:0] OP_MULT   = 3'b010;
  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       accept, finish, retire;

  // Handshake readiness/validity are pure state decodes, never combinational from the far side.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign finish    = (state == EXEC) && (cnt == 8'd1);
  assign retire    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (finish) state_nx = DONE;
      DONE:    if (retire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      cnt       <= '0;
      out_y     <= '0;
    end else begin
      alu_start <= accept;
      if (accept) begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        alu_op <= in_op;
        cnt    <= (in_op == OP_MULT) ? MULT_LOAD : 8'd1;
      end else if (state == EXEC) begin
        cnt <= cnt - 8'd1;
      end
      if (finish) out_y <= alu_y;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      perf_cnt <= '0;
    else if (retire) perf_cnt <= perf_cnt + 16'd1;
  end

  assign op_count = perf_cnt;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu32_issue.sv
// Self-checking bench for alu32_issue: emulates the ALU and checks results, latency and handshakes.
module tb_alu32_issue;

  localparam int unsigned MC = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_a, alu_b, alu_y, out_y;
  logic [2:0]  alu_op;
  logic        alu_start, out_valid, out_ready;
  logic [15:0] op_count;

  int          nchk = 0;
  int          nfail = 0;
  longint      cyc = 0;
  logic [15:0] exp_count = '0;

  alu32_issue #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] d;
    d = a - b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return d;
      3'd2:    return a * b;
      3'd3:    return a ^ b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return {31'b0, d[31]};
      default: return ~(a | b);
    endcase
  endfunction

  // Stand-in ALU fed from the DUT's registered operands
  always_comb alu_y = ref_alu(alu_a, alu_b, alu_op);

  function automatic logic [15:0] exp_opc();
`ifdef ALU_ISSUE_PERF_EN
    return exp_count;
`else
    return 16'h0000;
`endif
  endfunction

  // Drives one transaction starting at a negedge; returns observations for the caller to judge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int hold, input bit noise,
                       output logic [31:0] y, output int lat, output int starts,
                       output bit stable, output bit hs_ok, output longint acc_cyc);
    hs_ok = (in_ready === 1'b1);
    stable = 1'b1; starts = 0; lat = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    if (alu_start === 1'b1) starts++;
    while (out_valid !== 1'b1 && lat < 400) begin
      if (alu_a !== a || alu_b !== b || alu_op !== op) stable = 1'b0;
      if (in_ready !== 1'b0) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (alu_start === 1'b1) starts++;
    end
    y = out_y;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'b1; in_a = ~a; in_b = $urandom; in_op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (out_y !== y || out_valid !== 1'b1 || in_ready !== 1'b0 || alu_start !== 1'b0) hs_ok = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (lat < 400) exp_count = exp_count + 16'd1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    nchk++;
    if ({in_ready, out_valid, alu_start, alu_op} !== 6'b100000 || alu_a !== '0 || alu_b !== '0 ||
        out_y !== '0 || op_count !== '0) begin
      nfail++;
      $display("FAIL reset: in_ready=%b out_valid=%b alu_start=%b alu_op=%h alu_a=%h alu_b=%h out_y=%h op_count=%h, required 1 0 0 0 0 0 0 0",
               in_ready, out_valid, alu_start, alu_op, alu_a, alu_b, out_y, op_count);
    end
  endtask

  task automatic test_add();
    logic [31:0] y; int lat, st; bit stb, hs; longint ac;
    do_op(32'd5, 32'd7, 3'b000, 2, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (y !== 32'h0000000C) begin nfail++; $display("FAIL add_result: got %h required 0000000c", y); end
    nchk++; if (lat !== 1) begin nfail++; $display("FAIL add_latency: got %0d required 1", lat); end
    nchk++; if (hs !== 1'b1) begin nfail++; $display("FAIL add_handshake: in_ready/out_valid sequence wrong"); end
  endtask

  task automatic test_sub_slt();
    logic [31:0] y; int lat, st; bit stb, hs; longint ac;
    do_op(32'd3, 32'd5, 3'b001, 0, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (y !== 32'hFFFFFFFE) begin nfail++; $display("FAIL sub_result: got %h required fffffffe", y); end
    do_op(32'd3, 32'd5, 3'b110, 0, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (y !== 32'h00000001) begin nfail++; $display("FAIL slt_result: got %h required 00000001", y); end
  endtask

  task automatic test_mult();
    logic [31:0] y; int lat, st; bit stb, hs; longint ac;
    do_op(32'd6, 32'd7, 3'b010, 1, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (y !== 32'h0000002A) begin nfail++; $display("FAIL mult_result: got %h required 0000002a", y); end
    nchk++; if (lat !== int'(MC)) begin nfail++; $display("FAIL mult_latency: got %0d required %0d", lat, MC); end
    nchk++; if (st !== 1) begin nfail++; $display("FAIL mult_start_pulses: got %0d required 1", st); end
    nchk++; if (stb !== 1'b1) begin nfail++; $display("FAIL mult_operand_stability: alu inputs changed during EXEC"); end
  endtask

  task automatic test_backpressure();
    logic [31:0] y; int lat, st; bit stb, hs; longint ac;
    do_op(32'h12345678, 32'h0F0F0F0F, 3'b011, 10, 1'b1, y, lat, st, stb, hs, ac);
    nchk++; if (y !== 32'h1D3B5977) begin nfail++; $display("FAIL bp_result: got %h required 1d3b5977", y); end
    nchk++; if (hs !== 1'b1 || st !== 1) begin nfail++; $display("FAIL bp_hold: stall/release behaviour wrong (starts=%0d required 1)", st); end
  endtask

  task automatic test_reset_mid_mult();
    bit seen = 1'b0, rdy_ok = 1'b1;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd11; in_op = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
    end
    nchk++; if (seen || !rdy_ok) begin nfail++; $display("FAIL reset_abort: result_seen=%b in_ready_ok=%b, required 0 1", seen, rdy_ok); end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] a, b, y; logic [2:0] op; int lat, st, hold, bad, prev_gap, want;
    bit stb, hs; longint ac, prev_ac;
    bad = 0; prev_ac = -1; prev_gap = 0;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      hold = (i < 4) ? 0 : int'($urandom_range(0, 3));
      do_op(a, b, op, hold, 1'b1, y, lat, st, stb, hs, ac);
      want = (op == 3'b010) ? int'(MC) : 1;
      if (y !== ref_alu(a, b, op) || lat !== want || st !== 1 || !stb || !hs) begin
        bad++;
        $display("FAIL random_op%0d: op=%0d got y=%h lat=%0d, required y=%h lat=%0d", i, op, y, lat, ref_alu(a, b, op), want);
      end
      if (prev_ac >= 0 && ac - prev_ac != longint'(prev_gap)) begin
        bad++;
        $display("FAIL random_period%0d: got %0d cycles required %0d", i, ac - prev_ac, prev_gap);
      end
      prev_ac = ac;
      prev_gap = want + hold + 2;
    end
    nchk++; if (bad != 0) nfail++;
  endtask

  task automatic test_perf();
    logic [31:0] y; int lat, st; bit stb, hs; longint ac;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; exp_count = '0;
    for (int i = 0; i < 3; i++) do_op(32'(i), 32'd1, 3'b101, 0, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (op_count !== exp_opc()) begin nfail++; $display("FAIL perf_three: got %h required %h", op_count, exp_opc()); end
`ifdef ALU_ISSUE_PERF_EN
    force dut.perf_cnt = 16'hFFFF;
    #1 release dut.perf_cnt;
    exp_count = 16'hFFFF;
`endif
    do_op(32'd1, 32'd2, 3'b100, 0, 1'b0, y, lat, st, stb, hs, ac);
    nchk++; if (op_count !== exp_opc()) begin nfail++; $display("FAIL perf_wrap: got %h required %h", op_count, exp_opc()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add();
    test_sub_slt();
    test_mult();
    test_backpressure();
    nchk++; if (op_count !== exp_opc()) begin nfail++; $display("FAIL op_count_mid: got %h required %h", op_count, exp_opc()); end
    test_reset_mid_mult();
    test_random_back_to_back();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
